// File: rtl/bit_serial_accum.sv
// bit_serial_accum
//   Bit-serial two's-complement accumulator for the ADPCM predictor datapath.
//   Sums NTERMS serial words (WIDTH bits each, LSB first) through one full
//   adder and a WIDTH-bit circulating shift register. A frame FSM sequences
//   the words. sum_part is captured after PART_TERMS words, sum_full after
//   NTERMS words, and done pulses for one cycle with sum_full.
//
//   Optional build macro: BIT_SERIAL_ACCUM_OVF_EN enables the sticky signed
//   overflow flag; when undefined, ovf is tied to 0.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high reset
//   start    in   begin accumulation (sampled in IDLE only)
//   a        in   serial operand bit, LSB first
//   busy     out  high while accumulating
//   done     out  one-cycle pulse when sum_full / ovf update
//   sum_part out  sum of words 0..PART_TERMS-1
//   sum_full out  sum of words 0..NTERMS-1
//   ovf      out  sticky signed-overflow flag of the last accumulation
//
// state | meaning
// IDLE  | waiting for start; sr and cy hold
// ACC   | shifting one operand bit per cycle through the adder
module bit_serial_accum #(
    parameter int WIDTH      = 16,
    parameter int NTERMS     = 8,
    parameter int PART_TERMS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_part,
    output logic [WIDTH-1:0] sum_full,
    output logic             ovf
);

    localparam int BW = $clog2(WIDTH);
    localparam int TW = (NTERMS > 1) ? $clog2(NTERMS) : 1;

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0]    termcnt_q, termcnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] sum_part_q, sum_part_d;
    logic [WIDTH-1:0] sum_full_q, sum_full_d;
    logic             done_q, done_d;

    logic             b, s, c;
    logic             last_bit, last_word, part_word;
    logic [WIDTH-1:0] sr_next;

    assign last_bit  = (bitcnt_q == BW'(WIDTH - 1));
    assign last_word = (termcnt_q == TW'(NTERMS - 1));
    assign part_word = (termcnt_q == TW'(PART_TERMS - 1));

    // Word 0 loads: the recirculated bit is masked so the adder passes a.
    assign b       = (termcnt_q == '0) ? 1'b0 : sr_q[0];
    assign s       = a ^ b ^ cy_q;
    assign c       = (a & b) | (a & cy_q) | (b & cy_q);
    assign sr_next = {s, sr_q[WIDTH-1:1]};

`ifdef BIT_SERIAL_ACCUM_OVF_EN
    logic ovf_acc_q, ovf_acc_d;
    logic ovf_q, ovf_d;
    logic ovf_word;

    // At the MSB, cy_q is the carry into the sign bit and c the carry out.
    assign ovf_word = last_bit && (termcnt_q != '0) && (cy_q != c);
    assign ovf      = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        termcnt_d  = termcnt_q;
        sr_d       = sr_q;
        cy_d       = cy_q;
        sum_part_d = sum_part_q;
        sum_full_d = sum_full_q;
        done_d     = 1'b0;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
        ovf_acc_d  = ovf_acc_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACC;
                    bitcnt_d  = '0;
                    termcnt_d = '0;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
                    ovf_acc_d = 1'b0;
`endif
                end
            end
            ACC: begin
                sr_d = sr_next;
                cy_d = last_bit ? 1'b0 : c;
                if (last_bit) begin
                    bitcnt_d = '0;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
                    ovf_acc_d = ovf_acc_q | ovf_word;
`endif
                    if (part_word) begin
                        sum_part_d = sr_next;
                    end
                    if (last_word) begin
                        state_d    = IDLE;
                        termcnt_d  = '0;
                        sum_full_d = sr_next;
                        done_d     = 1'b1;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
                        ovf_d      = ovf_acc_q | ovf_word;
`endif
                    end else begin
                        termcnt_d = termcnt_q + 1'b1;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            termcnt_q  <= '0;
            sr_q       <= '0;
            cy_q       <= 1'b0;
            sum_part_q <= '0;
            sum_full_q <= '0;
            done_q     <= 1'b0;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
            ovf_acc_q  <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            termcnt_q  <= termcnt_d;
            sr_q       <= sr_d;
            cy_q       <= cy_d;
            sum_part_q <= sum_part_d;
            sum_full_q <= sum_full_d;
            done_q     <= done_d;
`ifdef BIT_SERIAL_ACCUM_OVF_EN
            ovf_acc_q  <= ovf_acc_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy     = (state_q == ACC);
    assign done     = done_q;
    assign sum_part = sum_part_q;
    assign sum_full = sum_full_q;

endmodule

// File: tb/tb_bit_serial_accum.sv
// Testbench for bit_serial_accum with default parameters (16 x 8, part 6).
module tb_bit_serial_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        a;
    logic        busy;
    logic        done;
    logic [15:0] sum_part;
    logic [15:0] sum_full;
    logic        ovf;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    logic [15:0] prev_full = 16'h0;

`ifdef BIT_SERIAL_ACCUM_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0][15:0] w;
        logic [15:0]      ep;
        logic [15:0]      ef;
        logic             eo;
        int               pulse_at;
    } vec_t;

    vec_t vecs[7];

    bit_serial_accum #(.WIDTH(16), .NTERMS(8), .PART_TERMS(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .busy     (busy),
        .done     (done),
        .sum_part (sum_part),
        .sum_full (sum_full),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Entered away from an edge with the DUT idle; returns #1 after the
    // sum_full edge, i.e. inside the done cycle.
    task automatic run_frame(input vec_t v, input string tag);
        logic [15:0] wd;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_k"}, {31'b0, busy}, 32'd1);
        for (int n = 1; n <= 128; n++) begin
            wd = v.w[(n - 1) / 16];
            a  = wd[(n - 1) % 16];
            if (n == v.pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 96)
                chk({tag, "_part"}, {16'b0, sum_part}, {16'b0, v.ep});
            if (n == 127) begin
                chk({tag, "_done_early"}, {31'b0, done}, 32'd0);
                chk({tag, "_full_hold"}, {16'b0, sum_full}, {16'b0, prev_full});
            end
        end
        chk({tag, "_full"}, {16'b0, sum_full}, {16'b0, v.ef});
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, v.eo & OVF_ON});
        prev_full = v.ef;
    endtask

    initial begin
        vecs[0].w = {8{16'h0001}};
        vecs[0].ep = 16'h0006; vecs[0].ef = 16'h0008; vecs[0].eo = 1'b0; vecs[0].pulse_at = -1;
        vecs[1].w = {8{16'hFFFF}};
        vecs[1].ep = 16'hFFFA; vecs[1].ef = 16'hFFF8; vecs[1].eo = 1'b0; vecs[1].pulse_at = 50;
        vecs[2].w = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h7FFF};
        vecs[2].ep = 16'h8000; vecs[2].ef = 16'h8000; vecs[2].eo = 1'b1; vecs[2].pulse_at = -1;
        vecs[3].w = {8{16'h0000}};
        vecs[3].ep = 16'h0000; vecs[3].ef = 16'h0000; vecs[3].eo = 1'b0; vecs[3].pulse_at = -1;
        vecs[4].w = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000};
        vecs[4].ep = 16'h0000; vecs[4].ef = 16'h0000; vecs[4].eo = 1'b1; vecs[4].pulse_at = -1;
        vecs[5].w = {16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF};
        vecs[5].ep = 16'h7FFF; vecs[5].ef = 16'h8000; vecs[5].eo = 1'b1; vecs[5].pulse_at = -1;
        vecs[6].w = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        vecs[6].ep = 16'h0015; vecs[6].ef = 16'h0024; vecs[6].eo = 1'b0; vecs[6].pulse_at = -1;

        reset = 1'b1; start = 1'b0; a = 1'b0;
        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_part", {16'b0, sum_part}, 32'd0);
        chk("rst_full", {16'b0, sum_full}, 32'd0);
        chk("rst_ovf",  {31'b0, ovf}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // Frames 0..3 back to back: start is raised inside each done cycle.
        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("v%0d", i));

        // Idle with a toggling: nothing may move.
        a = 1'b1;
        repeat (3) begin @(posedge clk); #1; a = ~a; end
        chk("idle_done", {31'b0, done}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_full", {16'b0, sum_full}, {16'b0, vecs[3].ef});
        chk("idle_part", {16'b0, sum_part}, {16'b0, vecs[3].ep});

        for (int i = 4; i < 6; i++) run_frame(vecs[i], $sformatf("v%0d", i));
        @(posedge clk); #1;
        chk("done_pulse_len", {31'b0, done}, 32'd0);

        // Mid-frame asynchronous reset after edge k+40.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin a = 1'($urandom); @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_part", {16'b0, sum_part}, 32'd0);
        chk("mrst_full", {16'b0, sum_full}, 32'd0);
        chk("mrst_ovf",  {31'b0, ovf}, 32'd0);
        prev_full = 16'h0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_frame(vecs[6], "v6");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
